swivm_uart_tx: RTL and testbench

Console output peripheral for the swivm CPU. Sits directly downstream of the core: the CPU's memory-mapped write to the console address drives a one-cycle write strobe into this block. The block buffers bytes in a small FIFO and serialises them as 8N1 asynchronous frames on a single `tx` line. It gives the test bench and FPGA top a visible character stream from running programs.

---
 rtl/swivm_uart_tx_pkg.sv | 19 +
 rtl/swivm_fifo.sv | 87 ++++++++
 rtl/swivm_uart_tx.sv | 134 +++++++++++++
 tb/tb_swivm_uart_tx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swivm_uart_tx_pkg.sv
// Shared definitions for the swivm console transmitter: FSM encodings,
// frame geometry and the console address decode used by the CPU.
package swivm_uart_tx_pkg;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t UART_IDLE  = 2'd0;
  localparam uart_state_t UART_START = 2'd1;
  localparam uart_state_t UART_DATA  = 2'd2;
  localparam uart_state_t UART_STOP  = 2'd3;

  localparam logic [2:0] UART_LAST_BIT = 3'd7;

  // CPU-side decode of the console register address.
  function automatic logic is_console_addr(input logic [31:0] addr);
    return (addr == 32'h1000_0000);
  endfunction

endpackage

// File: rtl/swivm_fifo.sv
// Parameterised synchronous FIFO with registered full/empty flags.
// Pushes while full are dropped; pops while empty are ignored.
module swivm_fifo
  import swivm_uart_tx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nxt_s;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic             full_r;
  logic             empty_r;

  // Acceptance is judged on the registered count only, so a pop in the
  // same cycle never frees room for a write that arrives while full.
  always_comb begin
    push_ok_s   = 1'b0;
    pop_ok_s    = 1'b0;
    count_nxt_s = count_r;
    if (push && (count_r < DEPTH_CNT)) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
    if (pop && (count_r != {(AW+1){1'b0}})) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + (AW+1)'(1);
      2'b01:   count_nxt_s = count_r - (AW+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_CNT);
      empty_r <= (count_nxt_s == {(AW+1){1'b0}});
    end
  end

  // Storage array; contents need no reset because the count gates reads.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/swivm_uart_tx.sv
// Console transmitter: buffers CPU write strobes in a FIFO and sends each
// byte as an 8N1 frame on tx (LSB first, idle high).
module swivm_uart_tx
  import swivm_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_t state_r;
  logic [BW-1:0] baud_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          tx_r;
  logic          busy_r;

  logic          pop_s;
  logic          baud_done_s;
  logic [7:0]    fifo_rdata_s;
  logic          fifo_empty_s;
  logic          fifo_full_s;

  swivm_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en),
    .pop   (pop_s),
    .wdata (wr_data),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Pop request and bit-period terminal count.
  always_comb begin
    pop_s       = 1'b0;
    baud_done_s = 1'b0;
    if ((state_r == UART_IDLE) && !fifo_empty_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    baud_done_s = (baud_r == BAUD_LAST);
  end

  // Frame sequencer; tx and busy are set alongside each state change so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= UART_IDLE;
      baud_r    <= {BW{1'b0}};
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        UART_IDLE: begin
          baud_r <= {BW{1'b0}};
          if (pop_s) begin
            shift_r <= fifo_rdata_s;
            state_r <= UART_START;
            tx_r    <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        UART_START: begin
          if (baud_done_s) begin
            baud_r    <= {BW{1'b0}};
            bit_idx_r <= 3'd0;
            state_r   <= UART_DATA;
            tx_r      <= shift_r[0];
          end else begin
            baud_r    <= baud_r + BW'(1);
          end
        end
        UART_DATA: begin
          if (baud_done_s) begin
            baud_r <= {BW{1'b0}};
            if (bit_idx_r == UART_LAST_BIT) begin
              state_r <= UART_STOP;
              tx_r    <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
            end
          end else begin
            baud_r <= baud_r + BW'(1);
          end
        end
        UART_STOP: begin
          if (baud_done_s) begin
            baud_r  <= {BW{1'b0}};
            state_r <= UART_IDLE;
            busy_r  <= 1'b0;
          end else begin
            baud_r  <= baud_r + BW'(1);
          end
        end
        default: begin
          baud_r  <= {BW{1'b0}};
          state_r <= UART_IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign tx    = tx_r;
  assign busy  = busy_r;
  assign full  = fifo_full_s;
  assign empty = fifo_empty_s;

endmodule

// File: tb/tb_swivm_uart_tx.sv
// Bench for swivm_uart_tx: frame-level reference model compared every
// cycle, a line decoder, and directed scenarios with literal expectations.
module tb_swivm_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, busy, tx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  swivm_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: buffered bytes plus position within the current frame.
  logic [7:0] m_q[$];
  bit         m_active = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_en = 1'b0;

  function automatic logic model_tx();
    if (!m_active)          return 1'b1;
    else if (m_t < CPB)     return 1'b0;
    else if (m_t < 9 * CPB) return m_byte[(m_t - CPB) / CPB];
    else                    return 1'b1;
  endfunction

  initial begin : model_proc
    bit do_pop, do_push;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_q.delete();
        m_active = 1'b0;
        m_t = 0;
        m_en = 1'b1;
      end else begin
        do_pop  = !m_active && (m_q.size() > 0);
        do_push = wr_en && (m_q.size() < DEPTH);
        if (m_active) begin
          m_t++;
          if (m_t == FRAME) m_active = 1'b0;
        end else if (do_pop) begin
          m_byte = m_q.pop_front();
          m_active = 1'b1;
          m_t = 0;
        end
        if (do_push) m_q.push_back(wr_data);
      end
    end
  end

  initial begin : compare_proc
    forever begin
      @(negedge clk);
      if (m_en) begin
        check("tx",    {31'd0, tx},    {31'd0, model_tx()});
        check("busy",  {31'd0, busy},  {31'd0, m_active});
        check("empty", {31'd0, empty}, {31'd0, (m_q.size() == 0)});
        check("full",  {31'd0, full},  {31'd0, (m_q.size() == DEPTH)});
      end
    end
  end

  // Line decoder: samples mid-bit from each falling start edge.
  logic [7:0] rx_q[$];
  int         starts_q[$];
  bit         rx_busy = 1'b0;
  int         rx_start = 0;
  logic [7:0] rx_sh = 8'h00;
  logic       prev_tx = 1'b1;
  logic       busy_prev = 1'b0;
  int         busy_fall_cyc = 0;

  initial begin : rx_proc
    int off;
    forever begin
      @(negedge clk);
      if (!m_en || !rst_n) begin
        rx_busy = 1'b0;
      end else if (!rx_busy) begin
        if (prev_tx === 1'b1 && tx === 1'b0) begin
          rx_busy = 1'b1;
          rx_start = cyc;
          starts_q.push_back(cyc);
        end
      end else begin
        off = cyc - rx_start;
        if (off >= CPB && off < 9 * CPB && (off % CPB) == CPB / 2)
          rx_sh[(off - CPB) / CPB] = tx;
        if (off == 9 * CPB + CPB / 2) begin
          rx_q.push_back(rx_sh);
          rx_busy = 1'b0;
        end
      end
      if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
      prev_tx = tx;
      busy_prev = busy;
    end
  end

  task automatic write_byte(input logic [7:0] d, output int at_cyc);
    @(posedge clk); #1;
    wr_en = 1'b1;
    wr_data = d;
    at_cyc = cyc;
  endtask

  task automatic write_off();
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_rx(input int target, input int budget, input string nm);
    int k;
    k = 0;
    while (rx_q.size() < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(nm, rx_q.size(), target);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : main
    int w, base, s0, st, low, n, k;
    logic [7:0] exp_b;

    // Reset and idle line
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    low = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    check("idle_low_cycles", low, 0);

    // Single byte 0x55
    base = rx_q.size();
    s0 = starts_q.size();
    write_byte(8'h55, w);
    write_off();
    wait_rx(base + 1, 200, "single_rx_count");
    if (rx_q.size() > base) check("single_byte", rx_q[base], 32'h55);
    if (starts_q.size() > s0) begin
      check("single_latency", starts_q[s0] - w, 2);
      st = starts_q[s0];
      k = 0;
      while ((busy !== 1'b0 || cyc <= st + 1) && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("single_busy_len", busy_fall_cyc - st, 40);
    end else begin
      check("single_start_seen", starts_q.size(), s0 + 1);
    end
    repeat (5) @(negedge clk);

    // Back-to-back 0x41 then 0x42
    base = rx_q.size();
    s0 = starts_q.size();
    write_byte(8'h41, w);
    write_byte(8'h42, w);
    write_off();
    wait_rx(base + 2, 300, "b2b_rx_count");
    if (rx_q.size() >= base + 2) begin
      check("b2b_byte0", rx_q[base], 32'h41);
      check("b2b_byte1", rx_q[base + 1], 32'h42);
    end
    if (starts_q.size() >= s0 + 2)
      check("b2b_period", starts_q[s0 + 1] - starts_q[s0], 41);
    repeat (10) @(negedge clk);

    // Overflow: six writes into a depth-4 buffer
    base = rx_q.size();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 5) check("ovf_full_after_5", {31'd0, full}, 32'd1);
      wr_en = 1'b1;
      wr_data = 8'(i + 1);
    end
    write_off();
    wait_rx(base + 5, 600, "ovf_rx_count");
    repeat (100) @(negedge clk);
    check("ovf_no_sixth", rx_q.size(), base + 5);
    for (int i = 0; i < 5; i++) begin
      if (rx_q.size() > base + i) begin
        exp_b = 8'(i + 1);
        check("ovf_byte", rx_q[base + i], {24'd0, exp_b});
      end
    end

    // Pointer wrap: 20 bytes gated on full
    base = rx_q.size();
    n = 0;
    k = 0;
    while (n < 20 && k < 3000) begin
      @(posedge clk); #1;
      k++;
      if (!full) begin
        wr_en = 1'b1;
        wr_data = 8'(n);
        n++;
      end else begin
        wr_en = 1'b0;
      end
    end
    write_off();
    check("wrap_written", n, 20);
    wait_rx(base + 20, 1500, "wrap_rx_count");
    for (int i = 0; i < 20; i++) begin
      if (rx_q.size() > base + i) begin
        exp_b = 8'(i);
        check("wrap_byte", rx_q[base + i], {24'd0, exp_b});
      end
    end
    repeat (10) @(negedge clk);

    // Reset during data bit 3 of 0xA5 with two bytes queued
    base = rx_q.size();
    s0 = starts_q.size();
    write_byte(8'hA5, w);
    write_byte(8'h11, w);
    write_byte(8'h22, w);
    write_off();
    k = 0;
    while (starts_q.size() <= s0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("mid_start_seen", starts_q.size(), s0 + 1);
    if (starts_q.size() > s0) begin
      st = starts_q[s0];
      k = 0;
      while (cyc < st + 4 * CPB + 1 && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_empty", {31'd0, empty}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (150) @(negedge clk);
    check("mid_no_rx", rx_q.size(), base);
    check("mid_no_new_start", starts_q.size(), s0 + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
